// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// request legality check applied at accept time.
package lsu_pkg;

    localparam int unsigned RAM_SIZE = 256;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_RMW_RD = 2'b10,
        ST_WRITE  = 2'b11
    } state_e;

    // Halfwords need an even address, words a 4-byte aligned one; size 11 is never legal.
    function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and memory-side signals of the load/store unit.
// The slave modport is the unit; the master modport is the CPU plus memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/byte_lane_align.sv
// Combinational little-endian lane handling: load extract/extend and store merge.
// Shared by the LOAD path and the read-modify-write path.
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [4:0]  w_bsel;
    logic [4:0]  w_hsel;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_bsel = {i_off, 3'b000};
    assign w_hsel = {i_off[1], 4'b0000};

    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_load_data  = i_rdata;
        o_merge_data = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load_data                 = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merge_data                = i_rdata;
                o_merge_data[w_bsel +: 8]   = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load_data                 = {{16{i_signed & w_half[15]}}, w_half};
                o_merge_data                = i_rdata;
                o_merge_data[w_hsel +: 16]  = i_wdata[15:0];
            end
            default: begin
                o_load_data  = i_rdata;
                o_merge_data = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU MEM stage and word-addressed data memory.
// Sub-word stores run as read-modify-write; misaligned or illegal requests complete with an error.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    state_e      r_state;
    state_e      w_next;
    logic        r_we;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic        w_bad;
    logic        w_done;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_accept = bus.req_valid && (r_state == ST_IDLE);
    assign w_bad    = is_bad_req(bus.req_size, bus.req_addr[1:0]);
    assign w_done   = (r_state == ST_LOAD) || (r_state == ST_WRITE);

    byte_lane_align u_align (
        .i_size       (r_size),
        .i_signed     (r_signed),
        .i_off        (r_off),
        .i_rdata      (bus.mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_comb begin
        w_next   = r_state;
        w_mem_rd = 1'b0;
        w_mem_wr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_bad) begin
                    if (!bus.req_we)
                        w_next = ST_LOAD;
                    else if (bus.req_size == SZ_WORD)
                        w_next = ST_WRITE;
                    else
                        w_next = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                w_mem_rd = 1'b1;
                w_next   = ST_IDLE;
            end
            ST_RMW_RD: begin
                w_mem_rd = 1'b1;
                w_next   = ST_WRITE;
            end
            default: begin
                w_mem_wr = 1'b1;
                w_next   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= 2'b00;
            r_wdata      <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= 1'b0;
            if (w_accept) begin
                r_we        <= bus.req_we;
                r_signed    <= bus.req_signed;
                r_size      <= bus.req_size;
                r_off       <= bus.req_addr[1:0];
                r_wdata     <= bus.req_wdata;
                r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                r_mem_wdata <= bus.req_wdata;
                if (w_bad) begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                    r_resp_rdata <= 32'h0;
                end
            end
            // The RMW read beat turns the write-data register into the merged word.
            if (r_state == ST_RMW_RD)
                r_mem_wdata <= w_merge_data;
            if (w_done) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b0;
                r_resp_rdata <= r_we ? 32'h0 : w_load_data;
            end
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_rd     = w_mem_rd;
    assign bus.mem_wr     = w_mem_wr;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: responses are scoreboarded with their expected cycle.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
        int          id;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        preload;
    int          cyc;
    int          checks;
    int          errors;
    int          rd_cnt;
    int          wr_cnt;
    int          last_rd_cyc;
    int          last_wr_cyc;
    logic [31:0] last_rd_addr;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_dat;
    int          acc_cyc;
    exp_t        sb[$];
    logic [31:0] mem [RAM_SIZE];

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < int'(RAM_SIZE); i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;
            mem[5] <= 32'h11223344;
            mem[6] <= 32'hCAFEF00D;
        end else if (bus.mem_wr) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr[9:2]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_rd) begin
            rd_cnt++;
            last_rd_cyc  = cyc;
            last_rd_addr = bus.mem_addr;
        end
        if (bus.mem_wr) begin
            wr_cnt++;
            last_wr_cyc  = cyc;
            last_wr_addr = bus.mem_addr;
            last_wr_dat  = bus.mem_wdata;
        end
        chk("rd_wr_exclusive", {31'b0, bus.mem_rd & bus.mem_wr}, 32'h0);
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("resp%0d_err", e.id), {31'b0, bus.resp_err}, {31'b0, e.err});
                chk($sformatf("resp%0d_rdata", e.id), bus.resp_rdata, e.rdata);
                chk($sformatf("resp%0d_cycle", e.id), cyc, e.due);
            end
        end
    end

    // lat counts cycles from the accept edge to the resp_valid cycle.
    task automatic issue(input int id, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rdata, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept%0d", id), {31'b0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        acc_cyc = cyc;
        sb.push_back('{exp_err, exp_rdata, cyc + lat - 1, id});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 32'h0);
    endtask

    initial begin
        int wr0;
        int rd0;
        int a1;
        cyc = 0; checks = 0; errors = 0; rd_cnt = 0; wr_cnt = 0;
        last_rd_cyc = -1; last_wr_cyc = -1;
        last_rd_addr = 32'h0; last_wr_addr = 32'h0; last_wr_dat = 32'h0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        reset = 1'b1;
        preload = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_rd_wr", {30'b0, bus.mem_rd, bus.mem_wr}, 32'h0);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
        reset = 1'b0;

        // Loads of word 0x10 = 0x8899AABB
        issue(1, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 1'b0, 32'hFFFFFFAA, 2);
        issue(2, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 1'b0, 32'h000000AA, 2);
        issue(3, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFF8899, 2);
        issue(4, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000AABB, 2);
        issue(5, 1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFFFBB, 2);
        issue(6, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 1'b0, 32'h00008899, 2);
        drain();
        repeat (3) @(negedge clk);
        chk("rdata_hold", bus.resp_rdata, 32'h00008899);

        // Reset in the RMW read beat of a half store aborts it
        wr0 = wr_cnt;
        issue(7, 1'b1, SZ_HALF, 1'b0, 32'h10, 32'hAAAA5555, 1'b0, 32'h0, 3);
        @(negedge clk);
        chk("rmw_rd_before_reset", {31'b0, bus.mem_rd}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("abort_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("abort_resp_err", {31'b0, bus.resp_err}, 32'h0);
        chk("abort_resp_rdata", bus.resp_rdata, 32'h0);
        chk("abort_mem_addr", bus.mem_addr, 32'h0);
        chk("abort_mem_wdata", bus.mem_wdata, 32'h0);
        chk("abort_mem_rd_wr", {30'b0, bus.mem_rd, bus.mem_wr}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_write", wr_cnt, wr0);
        issue(8, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8899AABB, 2);
        drain();

        // Byte store to 0x13 via read-modify-write
        issue(9, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h12345677, 1'b0, 32'h0, 3);
        a1 = acc_cyc;
        drain();
        chk("bst_rd_cycle", last_rd_cyc, a1);
        chk("bst_rd_addr", last_rd_addr, 32'h10);
        chk("bst_wr_cycle", last_wr_cyc, a1 + 1);
        chk("bst_wr_addr", last_wr_addr, 32'h10);
        chk("bst_wr_data", last_wr_dat, 32'h7799AABB);
        issue(10, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h7799AABB, 2);

        // Half store into the upper lane of word 0x18
        issue(11, 1'b1, SZ_HALF, 1'b0, 32'h1A, 32'hFFFF1234, 1'b0, 32'h0, 3);
        issue(12, 1'b0, SZ_WORD, 1'b0, 32'h18, 32'h0, 1'b0, 32'h1234F00D, 2);
        issue(13, 1'b0, SZ_BYTE, 1'b1, 32'h1B, 32'h0, 1'b0, 32'h00000012, 2);
        drain();

        // Misaligned / illegal requests never touch memory
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        issue(14, 1'b1, SZ_WORD, 1'b0, 32'h22, 32'h55555555, 1'b1, 32'h0, 1);
        issue(15, 1'b0, SZ_HALF, 1'b1, 32'h15, 32'h0, 1'b1, 32'h0, 1);
        issue(16, 1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1);
        drain();
        repeat (2) @(negedge clk);
        chk("err_no_write", wr_cnt, wr0);
        chk("err_no_read", rd_cnt, rd0);
        chk("err_mem_unchanged", mem[8], 32'h0);

        // A request withdrawn while the unit is busy is ignored
        issue(17, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 1'b0, 32'h11223344, 2);
        @(negedge clk);
        chk("busy_not_ready", {31'b0, bus.req_ready}, 32'h0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h0BADF00D;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wr0 = wr_cnt;
        drain();
        repeat (3) @(negedge clk);
        chk("withdrawn_no_write", wr_cnt, wr0);
        chk("withdrawn_mem", mem[8], 32'h0);

        // Back-to-back: load then word store with no bubble
        issue(18, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h7799AABB, 2);
        a1 = acc_cyc;
        issue(19, 1'b1, SZ_WORD, 1'b0, 32'h14, 32'hDEADBEEF, 1'b0, 32'h0, 2);
        chk("b2b_accept_gap", acc_cyc - a1, 32'd2);
        issue(20, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 1'b0, 32'hDEADBEEF, 2);
        drain();
        chk("final_word14", mem[5], 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
